// File: rtl/alu_issue_ctrl.sv
// Single-issue sequencer that decodes R-type instructions, feeds a combinational ALU and writes results back.
// Optional performance counters are enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREG    = 32,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    input  logic            ld_en,
    input  logic [4:0]      ld_addr,
    input  logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [31:0]     alu_I,
    input  logic [XLEN-1:0] alu_o,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy,
    output logic            illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]     perf_retired,
    output logic [15:0]     perf_illegal
`endif
);

    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    logic [2:0]      state;
    logic [2:0]      state_nx;
    logic [31:0]     instr_q;
    logic [CW-1:0]   cnt;
    logic            legal_c;
    logic [XLEN-1:0] regs [NREG];

    logic [4:0] rs1_a;
    logic [4:0] rs2_a;
    logic [4:0] rd_a;

    assign rs1_a = instr_q[19:15];
    assign rs2_a = instr_q[24:20];
    assign rd_a  = instr_q[11:7];

    // Ready is combinational so a preload strobe blocks acceptance in the same cycle.
    assign instr_ready = (state == S_IDLE) && !ld_en;

    // Supported subset: add, sub, sll, or, and.
    always_comb begin
        legal_c = 1'b0;
        if (instr_q[6:0] == 7'b0110011) begin
            case ({instr_q[31:25], instr_q[14:12]})
                {7'h00, 3'd0},
                {7'h20, 3'd0},
                {7'h00, 3'd1},
                {7'h00, 3'd6},
                {7'h00, 3'd7}: legal_c = 1'b1;
                default:       legal_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (instr_valid && instr_ready) state_nx = S_DECODE;
            S_DECODE: state_nx = legal_c ? S_READ : S_IDLE;
            S_READ:   state_nx = S_EXEC;
            S_EXEC:   if (cnt == '0) state_nx = S_WB;
            S_WB:     state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Datapath, register file and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q  <= '0;
            cnt      <= '0;
            alu_rs1  <= '0;
            alu_rs2  <= '0;
            alu_I    <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            illegal  <= 1'b0;
            busy     <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
        end else begin
            wb_valid <= 1'b0;
            illegal  <= 1'b0;
            busy     <= (state_nx != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (ld_en && (ld_addr != 5'd0)) regs[ld_addr] <= ld_data;
                    if (instr_valid && instr_ready) instr_q <= instr;
                end
                S_DECODE: begin
                    if (!legal_c) illegal <= 1'b1;
                end
                S_READ: begin
                    alu_rs1 <= (rs1_a == 5'd0) ? '0 : regs[rs1_a];
                    alu_rs2 <= (rs2_a == 5'd0) ? '0 : regs[rs2_a];
                    alu_I   <= instr_q;
                    cnt     <= CW'(ALU_LAT - 1);
                end
                S_EXEC: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                end
                S_WB: begin
                    if (rd_a != 5'd0) regs[rd_a] <= alu_o;
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_a;
                    wb_data  <= alu_o;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    // Free-running event counters; both wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired <= '0;
            perf_illegal <= '0;
        end else begin
            if (state == S_WB) perf_retired <= perf_retired + 32'd1;
            if ((state == S_DECODE) && !legal_c) perf_illegal <= perf_illegal + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl together with a behavioural R-type ALU.
module tb_alu_issue_ctrl;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ALU_LAT = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;
    logic            ld_en;
    logic [4:0]      ld_addr;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [31:0]     alu_I;
    logic [XLEN-1:0] alu_o;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            busy;
    logic            illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0]     perf_retired;
    logic [15:0]     perf_illegal;
`endif

    alu_issue_ctrl #(.XLEN(XLEN), .NREG(32), .ALU_LAT(ALU_LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_I       (alu_I),
        .alu_o       (alu_o),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy        (busy),
        .illegal     (illegal)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_retired(perf_retired),
        .perf_illegal(perf_illegal)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural combinational ALU
    always_comb begin
        case ({alu_I[31:25], alu_I[14:12]})
            {7'h00, 3'd0}: alu_o = alu_rs1 + alu_rs2;
            {7'h20, 3'd0}: alu_o = alu_rs1 - alu_rs2;
            {7'h00, 3'd1}: alu_o = alu_rs1 << alu_rs2[4:0];
            {7'h00, 3'd6}: alu_o = alu_rs1 | alu_rs2;
            {7'h00, 3'd7}: alu_o = alu_rs1 & alu_rs2;
            default:       alu_o = '0;
        endcase
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t         sb_q[$];
    logic [31:0] shadow [32];
    int          checks = 0;
    int          errors = 0;
    int          n_ret  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] model(input logic [31:0] ins);
        logic [31:0] a;
        logic [31:0] b;
        a = shadow[ins[19:15]];
        b = shadow[ins[24:20]];
        case ({ins[31:25], ins[14:12]})
            {7'h00, 3'd0}: return a + b;
            {7'h20, 3'd0}: return a - b;
            {7'h00, 3'd1}: return a << b[4:0];
            {7'h00, 3'd6}: return a | b;
            {7'h00, 3'd7}: return a & b;
            default:       return 32'd0;
        endcase
    endfunction

    // Writeback monitor: every wb_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", 64'(wb_valid), 64'd0);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                check("wb_rd", 64'(wb_rd), 64'(e.rd));
                check("wb_data", 64'(wb_data), 64'(e.data));
            end
        end
    end

    task automatic push_expect(input logic [31:0] ins, input bit use_exp, input logic [31:0] exp_data);
        wb_t e;
        e.rd   = ins[11:7];
        e.data = use_exp ? exp_data : model(ins);
        sb_q.push_back(e);
        if (e.rd != 5'd0) shadow[e.rd] = e.data;
        n_ret++;
    endtask

    // Waits from the accept edge until writeback or illegal, checking latency and pulse width.
    task automatic wait_done(input bit exp_illegal, output logic [31:0] rs1_seen);
        int k;
        bit done;
        k = 0;
        done = 1'b0;
        rs1_seen = '0;
        while (!done && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 3) rs1_seen = alu_rs1;
            if (wb_valid || illegal) done = 1'b1;
        end
        check("done_timeout", 64'(done), 64'd1);
        if (exp_illegal) begin
            check("ill_latency", 64'(k), 64'd1);
            check("ill_pulse", 64'(illegal), 64'd1);
            check("ill_no_wb", 64'(wb_valid), 64'd0);
            check("ill_busy", 64'(busy), 64'd0);
        end else begin
            check("wb_latency", 64'(k), 64'(3 + ALU_LAT));
        end
        @(posedge clk);
        #1;
        check("pulse_end", 64'({wb_valid, illegal}), 64'd0);
        check("idle_after", 64'(busy), 64'd0);
    endtask

    task automatic issue(input logic [31:0] ins, input bit exp_illegal, input bit use_exp,
                         input logic [31:0] exp_data, output logic [31:0] rs1_seen);
        int w;
        w = 0;
        while (!instr_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("ready_wait", 64'(instr_ready), 64'd1);
        if (!exp_illegal) push_expect(ins, use_exp, exp_data);
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        wait_done(exp_illegal, rs1_seen);
    endtask

    task automatic preload(input logic [4:0] addr, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
        if (addr != 5'd0) shadow[addr] = data;
    endtask

    logic [31:0] rs1_seen;
    logic [31:0] rb;

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        #12;
        check("rst_ready", 64'(instr_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wb", 64'({wb_valid, wb_rd, illegal}), 64'd0);
        check("rst_alu", 64'({alu_rs1, alu_rs2}), 64'd0);
        check("rst_wbdata", 64'(wb_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: add x1 = x2 + x3
        preload(5'd2, 32'd10000);
        preload(5'd3, 32'd23456);
        issue(32'h003100b3, 1'b0, 1'b1, 32'd33456, rs1_seen);
        check("add_rs1", 64'(rs1_seen), 64'd10000);

        // Test 2: each op into x1, then read x1 back through x5 = x1 + x0
        rb = rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd5);
        issue(32'h403100b3, 1'b0, 1'b1, 32'hFFFFCB70, rs1_seen);
        issue(rb, 1'b0, 1'b1, 32'hFFFFCB70, rs1_seen);
        issue(32'h003110b3, 1'b0, 1'b1, 32'd10000, rs1_seen);
        issue(rb, 1'b0, 1'b1, 32'd10000, rs1_seen);
        issue(32'h003160b3, 1'b0, 1'b1, 32'h00007FB0, rs1_seen);
        issue(rb, 1'b0, 1'b1, 32'h00007FB0, rs1_seen);
        issue(32'h003170b3, 1'b0, 1'b1, 32'h00000300, rs1_seen);
        issue(rb, 1'b0, 1'b1, 32'h00000300, rs1_seen);

        // Test 3: write to x0 is dropped; x0 reads zero
        issue(32'h00310033, 1'b0, 1'b1, 32'd33456, rs1_seen);
        issue(rtype(7'h00, 5'd3, 5'd0, 3'd0, 5'd6), 1'b0, 1'b1, 32'd23456, rs1_seen);
        check("x0_rs1", 64'(rs1_seen), 64'd0);

        // Test 4: addi is dropped as illegal
        issue(32'h00310013, 1'b1, 1'b0, 32'd0, rs1_seen);
`ifdef ALU_ISSUE_PERF_EN
        check("perf_retired", 64'(perf_retired), 64'(n_ret));
        check("perf_illegal", 64'(perf_illegal), 64'd1);
`endif

        // Test 5: preload wins over a simultaneous offer; accept follows next cycle
        push_expect(rtype(7'h00, 5'd0, 5'd7, 3'd0, 5'd8), 1'b1, 32'hCAFE0123);
        shadow[7]   = 32'hCAFE0123;
        ld_en       = 1'b1;
        ld_addr     = 5'd7;
        ld_data     = 32'hCAFE0123;
        instr_valid = 1'b1;
        instr       = rtype(7'h00, 5'd0, 5'd7, 3'd0, 5'd8);
        #1;
        check("ld_blocks_ready", 64'(instr_ready), 64'd0);
        @(posedge clk);
        #1;
        check("ld_no_accept", 64'(busy), 64'd0);
        ld_en = 1'b0;
        #1;
        check("ld_ready_back", 64'(instr_ready), 64'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check("ld_then_accept", 64'(busy), 64'd1);
        wait_done(1'b0, rs1_seen);
        check("ld_rs1", 64'(rs1_seen), 64'hCAFE0123);

        // Test 6: reset during EXEC discards the writeback and clears registers
        instr_valid = 1'b1;
        instr       = 32'h003100b3;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("exec_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ready", 64'(instr_ready), 64'd1);
        check("mid_rst_alu", 64'({alu_rs1, alu_rs2}), 64'd0);
        check("mid_rst_I", 64'(alu_I), 64'd0);
        check("mid_rst_wb", 64'({wb_valid, wb_rd, illegal}), 64'd0);
        check("mid_rst_wbdata", 64'(wb_data), 64'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_wb", 64'(wb_valid), 64'd0);
        end
        issue(rtype(7'h00, 5'd0, 5'd1, 3'd0, 5'd9), 1'b0, 1'b1, 32'd0, rs1_seen);
        check("x1_cleared", 64'(rs1_seen), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
